serializador: RTL and testbench

SERIALIZADOR -- requirements
Module: serializador

---
 rtl/serializador.sv | 123 ++++++++++++
 tb/tb_serializador.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serializador.sv
// rtl/serializador.sv - byte-to-bit serializer with even parity trailer
//
// Pops one byte from an upstream queue (fila) per frame and sends it MSB first,
// followed by one even-parity bit, over a ready/valid serial interface.
//
// Ports:
//   clk_10KHz        in   single clock, rising edge
//   reset            in   asynchronous, active-high
//   enable_in        in   permits starting a new frame
//   len_in[3:0]      in   fila occupancy (0..8)
//   data_in[7:0]     in   head word of fila, valid while len_in != 0
//   dequeue_out      out  one-cycle pop strobe to fila (LOAD state only)
//   data_out         out  serial bit
//   valid_out        out  data_out carries a frame bit
//   last_out         out  current bit is the parity bit
//   ready_in         in   downstream accepts the current bit on this edge
//   busy_out         out  frame in progress
//   frame_count_out  out  completed frames, modulo 256

module serializador (
    input  logic       clk_10KHz,
    input  logic       reset,
    input  logic       enable_in,
    input  logic [3:0] len_in,
    input  logic [7:0] data_in,
    output logic       dequeue_out,
    output logic       data_out,
    output logic       valid_out,
    output logic       last_out,
    input  logic       ready_in,
    output logic       busy_out,
    output logic [7:0] frame_count_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] shift_reg;
    logic [2:0] bit_cnt;
    logic       parity;

    logic       can_start;
    assign can_start = enable_in && (len_in != 4'd0);

    // Outputs are registered and computed for the state being entered, so
    // each output always reflects the current state (Moore behaviour).
    always_ff @(posedge clk_10KHz or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            shift_reg       <= 8'd0;
            bit_cnt         <= 3'd0;
            parity          <= 1'b0;
            dequeue_out     <= 1'b0;
            data_out        <= 1'b0;
            valid_out       <= 1'b0;
            last_out        <= 1'b0;
            busy_out        <= 1'b0;
            frame_count_out <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_start) begin
                        state       <= LOAD;
                        dequeue_out <= 1'b1;
                        busy_out    <= 1'b1;
                    end
                end

                LOAD: begin
                    shift_reg   <= data_in;
                    bit_cnt     <= 3'd0;
                    parity      <= ^data_in;
                    state       <= SEND;
                    dequeue_out <= 1'b0;
                    data_out    <= data_in[7];
                    valid_out   <= 1'b1;
                    last_out    <= 1'b0;
                end

                SEND: begin
                    if (ready_in) begin
                        shift_reg <= {shift_reg[6:0], 1'b0};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state    <= PAR;
                            data_out <= parity;
                            last_out <= 1'b1;
                        end else begin
                            // Next bit to present is the one shifting into bit 7.
                            data_out <= shift_reg[6];
                        end
                    end
                end

                PAR: begin
                    if (ready_in) begin
                        frame_count_out <= frame_count_out + 8'd1;
                        data_out        <= 1'b0;
                        valid_out       <= 1'b0;
                        last_out        <= 1'b0;
                        if (can_start) begin
                            state       <= LOAD;
                            dequeue_out <= 1'b1;
                        end else begin
                            state       <= IDLE;
                            busy_out    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador.sv
// tb/tb_serializador.sv - scoreboard bench for serializador

`timescale 1ns/1ps

module tb_serializador;

    logic       clk_10KHz;
    logic       reset;
    logic       enable_in;
    logic [3:0] len_in;
    logic [7:0] data_in;
    logic       dequeue_out;
    logic       data_out;
    logic       valid_out;
    logic       last_out;
    logic       ready_in;
    logic       busy_out;
    logic [7:0] frame_count_out;

    serializador dut (
        .clk_10KHz       (clk_10KHz),
        .reset           (reset),
        .enable_in       (enable_in),
        .len_in          (len_in),
        .data_in         (data_in),
        .dequeue_out     (dequeue_out),
        .data_out        (data_out),
        .valid_out       (valid_out),
        .last_out        (last_out),
        .ready_in        (ready_in),
        .busy_out        (busy_out),
        .frame_count_out (frame_count_out)
    );

    initial clk_10KHz = 1'b0;
    always #50 clk_10KHz = ~clk_10KHz;

    int         total;
    int         bad;
    int         cyc;
    int         busy_cycles;
    int         deq_count;
    int         to_push;
    int         exp_frames;
    int         idle_hits;
    logic [7:0] fila[$];
    logic [1:0] exp_q[$];
    int         deq_cycles[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fila();
        len_in  = (fila.size() > 8) ? 4'd8 : 4'(fila.size());
        data_in = (fila.size() != 0) ? fila[0] : 8'h00;
    endtask

    // One clock: observe at the falling edge, update the fila model after the rising edge.
    task automatic step();
        logic       dq;
        logic [7:0] b;
        logic [1:0] e;
        @(negedge clk_10KHz);
        cyc++;
        dq = dequeue_out;
        if (busy_out) busy_cycles++;
        if (!busy_out) chk("idle_quiet", {29'd0, valid_out, last_out, dequeue_out & ~can_leave_idle()}, 32'd0);
        if (dequeue_out) begin
            chk("deq_nonempty", {31'd0, len_in != 4'd0}, 32'd1);
            deq_count++;
            deq_cycles.push_back(cyc);
            b = data_in;
            for (int i = 7; i >= 0; i--) exp_q.push_back({1'b0, b[i]});
            exp_q.push_back({1'b1, ^b});
        end
        if (valid_out && ready_in) begin
            if (exp_q.size() == 0) begin
                chk("spurious_bit", {31'd0, valid_out}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_bit", {31'd0, data_out}, {31'd0, e[0]});
                chk("last_bit", {31'd0, last_out}, {31'd0, e[1]});
                if (e[1]) exp_frames++;
            end
        end
        @(posedge clk_10KHz);
        #1;
        if (dq && fila.size() > 0) void'(fila.pop_front());
        while (fila.size() < 8 && to_push > 0) begin
            fila.push_back(8'($urandom));
            to_push--;
        end
        drive_fila();
    endtask

    // dequeue_out is never legal while busy_out is low.
    function automatic logic can_leave_idle();
        return 1'b0;
    endfunction

    task automatic run_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            step();
            if (!busy_out && fila.size() == 0 && to_push == 0) break;
        end
        chk("drained", {30'd0, busy_out, fila.size() != 0}, 32'd0);
    endtask

    task automatic wait_deq(input int bound);
        int start;
        start = deq_count;
        for (int i = 0; i < bound; i++) begin
            step();
            if (deq_count != start) break;
        end
        chk("deq_seen", {31'd0, deq_count != start}, 32'd1);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; busy_cycles = 0; deq_count = 0;
        to_push = 0; exp_frames = 0; idle_hits = 0;
        reset = 1'b1; enable_in = 1'b0; ready_in = 1'b0;
        drive_fila();

        // Reset state, asserted before any clock edge
        #3;
        chk("rst_outputs", {27'd0, dequeue_out, data_out, valid_out, last_out, busy_out}, 32'd0);
        chk("rst_count", {24'd0, frame_count_out}, 32'd0);
        step(); step();
        reset = 1'b0;

        // Single byte A5: 1,0,1,0,0,1,0,1 then parity 0
        enable_in = 1'b1; ready_in = 1'b1;
        busy_cycles = 0;
        fila.push_back(8'hA5); drive_fila();
        run_idle(40);
        chk("a5_deq", deq_count, 1);
        chk("a5_count", {24'd0, frame_count_out}, 32'd1);
        chk("a5_busy_len", busy_cycles, 10);
        chk("a5_exp_empty", exp_q.size(), 0);

        // Back-to-back 01 then FF
        busy_cycles = 0; deq_cycles.delete();
        fila.push_back(8'h01); fila.push_back(8'hFF); drive_fila();
        run_idle(60);
        chk("b2b_deq_count", deq_cycles.size(), 2);
        if (deq_cycles.size() == 2) chk("b2b_spacing", deq_cycles[1] - deq_cycles[0], 10);
        chk("b2b_busy_len", busy_cycles, 20);
        chk("b2b_count", {24'd0, frame_count_out}, 32'd3);

        // Stall 5 cycles on bit 3 of 3C
        busy_cycles = 0;
        fila.push_back(8'h3C); drive_fila();
        wait_deq(10);
        step(); step(); step();
        ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_data", {31'd0, data_out}, 32'd1);
            chk("stall_valid", {30'd0, valid_out, last_out}, 32'd2);
        end
        ready_in = 1'b1;
        run_idle(40);
        chk("stall_busy_len", busy_cycles, 15);
        chk("stall_count", {24'd0, frame_count_out}, 32'd4);

        // Empty fila with enable, then enable low with 3 queued words
        for (int i = 0; i < 50; i++) begin
            step();
            if (dequeue_out || busy_out || valid_out) idle_hits++;
        end
        chk("empty_quiet", idle_hits, 0);
        enable_in = 1'b0;
        fila.push_back(8'h12); fila.push_back(8'h34); fila.push_back(8'h56); drive_fila();
        chk("dis_len", {28'd0, len_in}, 32'd3);
        for (int i = 0; i < 50; i++) begin
            step();
            if (dequeue_out || busy_out || valid_out) idle_hits++;
        end
        chk("disabled_quiet", idle_hits, 0);
        enable_in = 1'b1;
        run_idle(80);
        chk("drain3_count", {24'd0, frame_count_out}, 32'd7);
        chk("model_count", {24'd0, frame_count_out}, exp_frames % 256);

        // Reset during bit 5
        fila.push_back(8'h96); drive_fila();
        wait_deq(10);
        for (int i = 0; i < 5; i++) step();
        chk("pre_rst_valid", {31'd0, valid_out}, 32'd1);
        #5 reset = 1'b1;
        #1;
        chk("mid_rst_outputs", {27'd0, dequeue_out, data_out, valid_out, last_out, busy_out}, 32'd0);
        chk("mid_rst_count", {24'd0, frame_count_out}, 32'd0);
        exp_q.delete();
        exp_frames = 0;
        step(); step();
        fila.push_back(8'h5A); drive_fila();
        reset = 1'b0;
        #1;
        chk("rel_no_deq", {31'd0, dequeue_out}, 32'd0);
        run_idle(40);
        chk("restart_count", {24'd0, frame_count_out}, 32'd1);
        chk("restart_exp_empty", exp_q.size(), 0);

        // Counter wrap: 254 more frames reach 255, one more wraps to 0
        to_push = 254;
        run_idle(3000);
        chk("wrap_255", {24'd0, frame_count_out}, 32'd255);
        fila.push_back(8'hC3); drive_fila();
        run_idle(40);
        chk("wrap_0", {24'd0, frame_count_out}, 32'd0);
        chk("wrap_model", {24'd0, frame_count_out}, exp_frames % 256);
        chk("final_exp_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
